// File: rtl/aes_inv_addkey_stage.sv
// AES-128 inverse-cipher AddRoundKey stage: local round-key store, 128-bit XOR,
// and a one-deep registered output handshake that feeds the InvMixColumns stage.
module aes_inv_addkey_stage #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr_en,
  input  logic [3:0]   key_wr_idx,
  input  logic [127:0] key_wr_data,
  input  logic         key_clr,
  output logic         keys_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_col1,
  output logic [31:0]  out_col2,
  output logic [31:0]  out_col3,
  output logic [31:0]  out_col4,
  output logic         out_mix,
  output logic         out_last,
  output logic         out_err,
  output logic [15:0]  blk_cnt
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  logic [127:0] key_mem [0:NR];
  logic [NR:0]  valid_q, valid_d;
  logic         keys_ready_q, keys_ready_d;
  logic         key_wr_ok;

  logic         out_valid_q, out_valid_d;
  logic [127:0] data_q, data_d;
  logic         mix_q, mix_d;
  logic         last_q, last_d;
  logic         err_q, err_d;
  logic [15:0]  blk_cnt_q, blk_cnt_d;

  logic         round_ok;
  logic [127:0] sel_key;
  logic         xfer;
  logic         drain;

  assign key_wr_ok = key_wr_en && (key_wr_idx <= NR_IDX);

  // Key contents survive reset; only the valid mask is cleared.
  always_ff @(posedge clk) begin
    if (key_wr_ok) begin
      key_mem[key_wr_idx] <= key_wr_data;
    end
  end

  // A write on the same cycle as key_clr keeps its own valid bit.
  always_comb begin
    valid_d = key_clr ? '0 : valid_q;
    if (key_wr_ok) begin
      valid_d[key_wr_idx] = 1'b1;
    end
    keys_ready_d = &valid_d;
  end

  assign round_ok = (in_round <= NR_IDX);
  assign sel_key  = round_ok ? key_mem[in_round] : '0;

  assign in_ready = keys_ready_q & (~out_valid_q | out_ready);
  assign xfer     = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    mix_d       = mix_q;
    last_d      = last_q;
    err_d       = err_q;
    blk_cnt_d   = blk_cnt_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      data_d      = in_state ^ sel_key;
      mix_d       = (in_round != 4'd0) && (in_round < NR_IDX);
      last_d      = (in_round == 4'd0);
      err_d       = ~round_ok;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    if (drain && last_q) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      keys_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      mix_q        <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      keys_ready_q <= keys_ready_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      mix_q        <= mix_d;
      last_q       <= last_d;
      err_q        <= err_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

  assign keys_ready = keys_ready_q;
  assign out_valid  = out_valid_q;
  assign out_col1   = data_q[127:96];
  assign out_col2   = data_q[95:64];
  assign out_col3   = data_q[63:32];
  assign out_col4   = data_q[31:0];
  assign out_mix    = mix_q;
  assign out_last   = last_q;
  assign out_err    = err_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_inv_addkey_stage.sv
// Bench for aes_inv_addkey_stage: FIPS-197 key schedule, directed vectors and a
// transaction-queue reference model that checks every cycle.
module tb_aes_inv_addkey_stage;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst, key_wr_en, key_clr, in_valid, out_ready;
  logic [3:0]   key_wr_idx, in_round;
  logic [127:0] key_wr_data, in_state;
  logic         keys_ready, in_ready, out_valid, out_mix, out_last, out_err;
  logic [31:0]  out_col1, out_col2, out_col3, out_col4;
  logic [15:0]  blk_cnt;

  always #5 clk = ~clk;

  aes_inv_addkey_stage #(.NR(NR)) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_clr(key_clr), .keys_ready(keys_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col1(out_col1), .out_col2(out_col2), .out_col3(out_col3), .out_col4(out_col4),
    .out_mix(out_mix), .out_last(out_last), .out_err(out_err), .blk_cnt(blk_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- FIPS-197 key expansion from first principles ----------------
  logic [127:0] rk [0:10];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [127:0] d;
    logic         mix;
    logic         last;
    logic         err;
  } exp_t;

  exp_t         q[$];
  logic [127:0] mkey [0:15];
  logic [NR:0]  mmask = '0;
  logic         mkr = 1'b0;
  logic [15:0]  mcnt = '0;

  always @(negedge clk) begin
    logic        exp_ir;
    logic [NR:0] nm;
    exp_t        e;
    chk("out_valid", out_valid, q.size() != 0);
    exp_ir = mkr & ((q.size() == 0) | out_ready);
    chk("in_ready", in_ready, exp_ir);
    chk("keys_ready", keys_ready, mkr);
    chk("blk_cnt", blk_cnt, mcnt);
    if (q.size() != 0) begin
      chk("out_data", {out_col1, out_col2, out_col3, out_col4}, q[0].d);
      chk("out_flags", {out_mix, out_last, out_err}, {q[0].mix, q[0].last, q[0].err});
    end
    if (rst) begin
      q.delete();
      mmask = '0;
      mkr   = 1'b0;
      mcnt  = '0;
    end else begin
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        if (e.last) mcnt++;
      end
      if (in_valid && exp_ir) begin
        e.d    = (in_round <= NR) ? in_state ^ mkey[in_round] : in_state;
        e.mix  = (in_round >= 1) && (in_round <= NR - 1);
        e.last = (in_round == 0);
        e.err  = (in_round > NR);
        q.push_back(e);
      end
      nm = key_clr ? '0 : mmask;
      if (key_wr_en && key_wr_idx <= NR) nm[key_wr_idx] = 1'b1;
      mmask = nm;
      mkr   = &nm;
    end
    if (key_wr_en && key_wr_idx <= NR) mkey[key_wr_idx] = key_wr_data;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic [127:0] exp;
    logic [2:0]   fl;   // {mix, last, err}
  } vec_t;

  vec_t tv [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] data);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = data;
    tick();
    key_wr_en = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] s [8];
    logic [127:0] a, x, y, nk;
    logic [15:0]  exp_blk;

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0; key_clr = 1'b0;
    in_valid = 1'b0; in_state = '0; in_round = '0; out_ready = 1'b0;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_cols", {out_col1, out_col2, out_col3, out_col4}, 128'h0);
    chk("reset_flags", {out_valid, out_mix, out_last, out_err, keys_ready}, 5'b0);
    chk("reset_blk", blk_cnt, 16'h0);

    // Test 1: keys 0..9 are not enough; idx 10 makes keys_ready rise one cycle later
    for (int i = 0; i < 10; i++) wr_key(4'(i), rk[i]);
    in_valid = 1'b1;
    #1;
    chk("t1_ten_keys_ready", keys_ready, 1'b0);
    chk("t1_ten_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 4'd10; key_wr_data = rk[10];
    #1;
    chk("t1_ready_before_edge", keys_ready, 1'b0);
    tick();
    key_wr_en = 1'b0;
    chk("t1_ready_after_edge", keys_ready, 1'b1);

    // Tests 2/3/5a: table of single transfers
    tv[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'd10,
              128'h7ad5fda789ef4e272bca100b3d9ff59f, 3'b000};
    tv[1] = '{128'h00102030405060708090a0b0c0d0e0f0, 4'd0,
              128'h00112233445566778899aabbccddeeff, 3'b010};
    tv[2] = '{128'hdeadbeef0123456789abcdeffedcba98, 4'd12,
              128'hdeadbeef0123456789abcdeffedcba98, 3'b001};
    tv[3] = '{128'h0f0e0d0c0b0a09080706050403020100, 4'd1,
              128'h0f0e0d0c0b0a09080706050403020100 ^ rk[1], 3'b100};
    tv[4] = '{128'hffffffffffffffffffffffffffffffff, 4'd9,
              ~rk[9], 3'b100};
    tv[5] = '{128'h123456789abcdef00fedcba987654321, 4'd15,
              128'h123456789abcdef00fedcba987654321, 3'b001};
    exp_blk = 16'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_state = tv[i].st; in_round = tv[i].rnd;
      chk("tv_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("tv_valid", out_valid, 1'b1);
      chk("tv_data", {out_col1, out_col2, out_col3, out_col4}, tv[i].exp);
      chk("tv_flags", {out_mix, out_last, out_err}, tv[i].fl);
      tick();
      if (tv[i].fl[1]) exp_blk++;
      chk("tv_blk_cnt", blk_cnt, exp_blk);
    end

    // Test 4: stall then back-to-back stream
    a = rnd128();
    out_ready = 1'b0; in_valid = 1'b1; in_state = a; in_round = 4'd3;
    tick();
    in_state = rnd128(); in_round = 4'd4;
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_in_ready", in_ready, 1'b0);
      chk("t4_stall_data", {out_col1, out_col2, out_col3, out_col4}, a ^ rk[3]);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s[k] = rnd128();
      in_state = s[k]; in_round = 4'(k + 1);
      tick();
      chk("t4_stream_valid", out_valid, 1'b1);
      chk("t4_stream_data", {out_col1, out_col2, out_col3, out_col4}, s[k] ^ rk[k + 1]);
    end
    in_valid = 1'b0;
    tick();
    chk("t4_drained", out_valid, 1'b0);

    // Test 5: key write to idx 5 in the same cycle as a round-5 transfer
    x = rnd128(); y = rnd128(); nk = rnd128();
    in_valid = 1'b1; in_state = x; in_round = 4'd5;
    key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = nk;
    tick();
    key_wr_en = 1'b0;
    chk("t5_old_key", {out_col1, out_col2, out_col3, out_col4}, x ^ rk[5]);
    in_state = y;
    tick();
    in_valid = 1'b0;
    chk("t5_new_key", {out_col1, out_col2, out_col3, out_col4}, y ^ nk);
    wr_key(4'd5, rk[5]);
    wr_key(4'd11, rnd128());

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_state  = rnd128();
      in_round  = 4'($urandom % 16);
      key_wr_en = ($urandom % 8) == 0;
      key_wr_idx  = 4'($urandom % 16);
      key_wr_data = rnd128();
      tick();
    end
    key_wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    // Test 6: reset with a held output, then key_clr
    out_ready = 1'b0; in_valid = 1'b1; in_state = rnd128(); in_round = 4'd0;
    tick();
    in_valid = 1'b0;
    chk("t6_held", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_keys_ready", keys_ready, 1'b0);
    chk("t6_rst_blk", blk_cnt, 16'h0);
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) wr_key(4'(i), rk[i]);
    chk("t6_reload", keys_ready, 1'b1);
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    chk("t6_key_clr", keys_ready, 1'b0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
